prio_arbiter: RTL and testbench
===============================

# prio_arbiter

Parametrised, registered request arbiter that turns a vector of request lines into a held, indexed grant with an acknowledge handshake. Single requests are latched until served. Selectable fixed-priority (highest index wins) or round-robin mode. Sits between raw input pins (e.g. `ui_in`) and a consumer that services one request at a time, driving `uo_out` with the grant index in the top-level wrapper.

## Interface
- `N`, 8: number of request lines; legal range 2..16.
- `IDX_W`, `$clog2(N)`: grant index width, derived, never overridden.

- `clk`  input  1  sole clock, rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `req`  input  N  request lines, sampled each rising edge; a 1-cycle pulse is enough to register a request.
- `mode`  input  1  0 = fixed priority, highest index wins; 1 = round-robin.
- `ack`  input  1  consumer accepts the current grant; ignored while `grant_valid`=0.
- `grant_valid`  output  1  a grant is presented.
- `grant_idx`  output  IDX_W  index of the granted request.
- `grant_onehot`  output  N  one-hot form of `grant_idx`; all-zero when `grant_valid`=0.
- `pend_cnt`  output  IDX_W+1  number of set bits in the pending register.

## Operation
- State:
  - pending register `P[N]`
  - round-robin pointer `ptr`, the last acked index
  - FSM with two states: `IDLE` (`grant_valid`=0) and `GRANT` (`grant_valid`=1).
- Clear mask: `clr` = `grant_onehot` when in `GRANT` with `ack`=1, else 0.
- Candidates: `C = (P & ~clr) | req`.
- Pending update every edge: `P <= C`.
  - A request stays pending until its grant is acked.
  - A `req` bit high in the ack cycle re-arms that bit.
- `IDLE`:
  - If `C`≠0, load the winner of `C` into `grant_idx`/`grant_onehot` and go to `GRANT`.
  - Otherwise stay.
- `GRANT`, `ack`=0:
  - `grant_idx`, `grant_onehot` and `grant_valid` hold unchanged regardless of `req` or `mode`.
- `GRANT`, `ack`=1:
  - `ptr <=` current `grant_idx`.
  - If `C`≠0, load the new winner and stay in `GRANT` (back-to-back, no bubble).
  - Otherwise go to `IDLE`.
- Winner selection, mode 0: highest set index of `C`.
- Winner selection, mode 1: first set bit of `C` scanning ascending from `(ptr+1) mod N` with wrap-around.
  - `ptr` is a mod-N value; for non-power-of-2 `N` it never exceeds N-1.
- `mode` is sampled only on a winner load. Changing it mid-grant has no effect on the held grant.
- `ptr` updates only on ack, in both modes, so a later switch to mode 1 continues fairly.
- `pend_cnt` = popcount(`P`), combinational from the register. Maximum value is N.
- `grant_idx` is always < N.

## Timing
- Reset (async assert, no clock needed):
  - `P`=0, `ptr`=N-1, state `IDLE`
  - `grant_valid`=0, `grant_idx`=0, `grant_onehot`=0, `pend_cnt`=0.
- `req` sampled at edge t with the arbiter idle: `grant_valid`=1 after edge t (1-cycle latency).
- Ack sampled at edge t:
  - next grant, if any, is visible after edge t;
  - otherwise `grant_valid` falls after edge t.
- Throughput: one grant per cycle with `ack` held high.
- `req` high during reset is ignored. The first grant appears after the first rising edge following `rst_n` release.
- Reset during `GRANT` drops the grant and all pending requests immediately.
- All grant outputs are registered. `pend_cnt` is one popcount deep after the `P` register.

## Test plan
- Reset: `rst_n`=0, `req`=8'hFF, no clocks -> all outputs 0. Release, mode 0, one edge -> `grant_valid`=1, `grant_idx`=7, `grant_onehot`=8'h80.
- Latching and back-to-back, mode 0:
  - 1-cycle pulse `req`=8'h14, `ack`=0 -> `grant_idx`=4 held for 5 cycles, `pend_cnt`=2.
  - `ack` for 1 cycle -> `grant_idx`=2 the next cycle, `pend_cnt`=1.
  - `ack` again -> `grant_valid`=0, `pend_cnt`=0.
- Round-robin fairness: mode 1 from reset, `req`=8'hFF held, `ack`=1 held -> `grant_idx` sequence 0,1,2,3,4,5,6,7,0 on consecutive cycles.
- Fixed-priority starvation: mode 0, `req`=8'h81 held, `ack`=1 held -> `grant_idx`=7 every cycle; bit 0 stays pending (`pend_cnt`=2).
- Ack with same-index re-request: mode 1, grant 3 with only bit 3 pending, `ack`=1 and `req`=8'h08 same cycle -> `grant_idx`=3, `grant_valid` stays 1, `pend_cnt`=1.
- Mid-operation reset: `grant_idx`=5 valid, `pend_cnt`=3, drop `rst_n` between edges -> all outputs 0 immediately. After release, mode 1 with `req`=8'hFF -> first grant is 0 (`ptr` restored to N-1).

Source files
------------

// File: rtl/prio_arbiter.sv
// prio_arbiter: latched request arbiter, fixed-priority or round-robin, with held grant and ack handshake
module prio_arbiter #(
    parameter  int N     = 8,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             mode,
    input  logic             ack,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx,
    output logic [N-1:0]     grant_onehot,
    output logic [IDX_W:0]   pend_cnt
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t           r_state;
    logic             r_valid;
    logic [N-1:0]     r_pend;
    logic [N-1:0]     r_onehot;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_ptr;

    logic             w_ack;
    logic             w_load;
    logic             w_any;
    logic [N-1:0]     w_clr;
    logic [N-1:0]     w_cand;
    logic [IDX_W-1:0] w_base;
    logic [IDX_W-1:0] w_hi_idx;
    logic [IDX_W-1:0] w_rr_idx;
    logic [IDX_W-1:0] w_win;
    logic [IDX_W:0]   w_cnt;

    // The round-robin scan starts after the grant being acked this cycle, so a
    // streak of acks walks the ring without waiting for the pointer register.
    assign w_ack  = (r_state == GRANT) && ack;
    assign w_clr  = w_ack ? r_onehot : '0;
    assign w_cand = (r_pend & ~w_clr) | req;
    assign w_any  = |w_cand;
    assign w_base = w_ack ? r_idx : r_ptr;
    assign w_load = (r_state == IDLE) || w_ack;
    assign w_win  = mode ? w_rr_idx : w_hi_idx;

    // Fixed priority: the last set bit seen in an ascending scan is the highest index.
    always_comb begin
        w_hi_idx = '0;
        for (int i = 0; i < N; i++)
            if (w_cand[i]) w_hi_idx = IDX_W'(i);
    end

    // Round robin: scan offsets N..1 so the nearest candidate after w_base is written last.
    always_comb begin
        logic [IDX_W-1:0] j;
        w_rr_idx = '0;
        j        = '0;
        for (int k = N; k >= 1; k--) begin
            j = IDX_W'((int'(w_base) + k) % N);
            if (w_cand[j]) w_rr_idx = j;
        end
    end

    // Population count of the pending register.
    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < N; i++)
            w_cnt = w_cnt + (IDX_W+1)'(r_pend[i]);
    end

    // Grant FSM with pending register and pointer; all grant outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_valid  <= 1'b0;
            r_pend   <= '0;
            r_onehot <= '0;
            r_idx    <= '0;
            r_ptr    <= IDX_W'(N - 1);
        end else begin
            r_pend <= w_cand;
            if (w_ack) r_ptr <= r_idx;
            if (w_load) begin
                if (w_any) begin
                    r_state  <= GRANT;
                    r_valid  <= 1'b1;
                    r_idx    <= w_win;
                    r_onehot <= N'(1) << w_win;
                end else begin
                    r_state  <= IDLE;
                    r_valid  <= 1'b0;
                    r_onehot <= '0;
                end
            end
        end
    end

    assign grant_valid  = r_valid;
    assign grant_idx    = r_idx;
    assign grant_onehot = r_onehot;
    assign pend_cnt     = w_cnt;
endmodule

// File: tb/tb_prio_arbiter.sv
// tb_prio_arbiter: directed scenarios plus randomized run against a behavioural model
module tb_prio_arbiter;
    localparam int N  = 8;
    localparam int IW = 3;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  req   = '0;
    logic          mode  = 1'b0;
    logic          ack   = 1'b0;
    logic          gv;
    logic [IW-1:0] gi;
    logic [N-1:0]  goh;
    logic [IW:0]   pc;

    int checks = 0;
    int errors = 0;

    // Behavioural model: a set of pending request numbers, a held grant, a last-served index.
    bit m_pend[N];
    bit m_valid;
    int m_idx;
    int m_ptr;

    always #5 clk = ~clk;

    prio_arbiter #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .mode(mode), .ack(ack),
        .grant_valid(gv), .grant_idx(gi), .grant_onehot(goh), .pend_cnt(pc)
    );

    task automatic model_reset();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_valid = 1'b0;
        m_idx   = 0;
        m_ptr   = N - 1;
    endtask

    function automatic int model_count();
        int n = 0;
        foreach (m_pend[i]) n += m_pend[i];
        return n;
    endfunction

    task automatic model_edge();
        bit c[N];
        bit served;
        int any;
        served = m_valid && ack;
        any = 0;
        for (int i = 0; i < N; i++) begin
            c[i] = (m_pend[i] && !(served && i == m_idx)) || req[i];
            any += c[i];
        end
        if (!m_valid || served) begin
            if (served) m_ptr = m_idx;
            if (any == 0) m_valid = 1'b0;
            else begin
                m_valid = 1'b1;
                if (!mode) begin
                    for (int i = 0; i < N; i++) if (c[i]) m_idx = i;
                end else begin
                    for (int k = 1; k <= N; k++)
                        if (c[(m_ptr + k) % N]) begin m_idx = (m_ptr + k) % N; break; end
                end
            end
        end
        foreach (m_pend[i]) m_pend[i] = c[i];
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        ack   = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        model_reset();
        rst_n = 1'b0; req = 8'hFF; mode = 1'b0;
        #2;
        checks++; if (gv !== 1'b0) begin errors++; $display("FAIL reset_gv got %0h exp 0", gv); end
        checks++; if (gi !== '0) begin errors++; $display("FAIL reset_gi got %0h exp 0", gi); end
        checks++; if (goh !== '0) begin errors++; $display("FAIL reset_goh got %0h exp 0", goh); end
        checks++; if (pc !== '0) begin errors++; $display("FAIL reset_pc got %0h exp 0", pc); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        req = '0;
        checks++; if (gv !== 1'b1) begin errors++; $display("FAIL first_gv got %0h exp 1", gv); end
        checks++; if (gi !== 3'd7) begin errors++; $display("FAIL first_gi got %0h exp 7", gi); end
        checks++; if (goh !== 8'h80) begin errors++; $display("FAIL first_goh got %0h exp 80", goh); end
        checks++; if (pc !== 4'd8) begin errors++; $display("FAIL first_pc got %0h exp 8", pc); end
    endtask

    task automatic test_latch();
        do_reset();
        mode = 1'b0; req = 8'h14;
        tick();
        req = '0;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) tick();
            checks++; if (gv !== 1'b1 || gi !== 3'd4) begin errors++; $display("FAIL latch_hold cyc %0d got v%0h i%0h exp v1 i4", c, gv, gi); end
            checks++; if (pc !== 4'd2) begin errors++; $display("FAIL latch_pc cyc %0d got %0h exp 2", c, pc); end
        end
        ack = 1'b1; tick(); ack = 1'b0;
        checks++; if (gv !== 1'b1 || gi !== 3'd2 || goh !== 8'h04) begin errors++; $display("FAIL latch_next got v%0h i%0h oh%0h exp v1 i2 oh04", gv, gi, goh); end
        checks++; if (pc !== 4'd1) begin errors++; $display("FAIL latch_next_pc got %0h exp 1", pc); end
        ack = 1'b1; tick(); ack = 1'b0;
        checks++; if (gv !== 1'b0 || goh !== '0) begin errors++; $display("FAIL latch_idle got v%0h oh%0h exp v0 oh00", gv, goh); end
        checks++; if (pc !== 4'd0) begin errors++; $display("FAIL latch_idle_pc got %0h exp 0", pc); end
    endtask

    task automatic test_round_robin();
        do_reset();
        mode = 1'b1; req = 8'hFF; ack = 1'b1;
        for (int k = 0; k < 9; k++) begin
            tick();
            checks++; if (gv !== 1'b1 || gi !== IW'(k % N)) begin errors++; $display("FAIL rr_seq step %0d got v%0h i%0h exp v1 i%0h", k, gv, gi, k % N); end
        end
        req = '0; ack = 1'b0;
    endtask

    task automatic test_starvation();
        do_reset();
        mode = 1'b0; req = 8'h81; ack = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++; if (gi !== 3'd7 || pc !== 4'd2) begin errors++; $display("FAIL starve step %0d got i%0h pc%0h exp i7 pc2", k, gi, pc); end
        end
        req = '0; ack = 1'b0;
    endtask

    task automatic test_rearm();
        do_reset();
        mode = 1'b1; req = 8'h08;
        tick();
        req = '0;
        checks++; if (gi !== 3'd3 || pc !== 4'd1) begin errors++; $display("FAIL rearm_pre got i%0h pc%0h exp i3 pc1", gi, pc); end
        ack = 1'b1; req = 8'h08;
        tick();
        ack = 1'b0; req = '0;
        checks++; if (gv !== 1'b1 || gi !== 3'd3 || pc !== 4'd1) begin errors++; $display("FAIL rearm got v%0h i%0h pc%0h exp v1 i3 pc1", gv, gi, pc); end
    endtask

    task automatic test_mode_switch();
        do_reset();
        mode = 1'b0; req = 8'h11;
        tick();
        mode = 1'b1; req = 8'h02;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (gv !== 1'b1 || gi !== 3'd4 || goh !== 8'h10) begin errors++; $display("FAIL mode_hold step %0d got v%0h i%0h exp v1 i4", k, gv, gi); end
        end
        req = '0; mode = 1'b0;
    endtask

    task automatic test_mid_reset();
        do_reset();
        mode = 1'b0; req = 8'h23;
        tick();
        req = '0;
        checks++; if (gi !== 3'd5 || pc !== 4'd3) begin errors++; $display("FAIL midrst_pre got i%0h pc%0h exp i5 pc3", gi, pc); end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (gv !== 1'b0 || gi !== '0 || goh !== '0 || pc !== '0) begin errors++; $display("FAIL midrst got v%0h i%0h oh%0h pc%0h exp all 0", gv, gi, goh, pc); end
        @(negedge clk);
        rst_n = 1'b1; mode = 1'b1; req = 8'hFF;
        tick();
        req = '0;
        checks++; if (gv !== 1'b1 || gi !== 3'd0) begin errors++; $display("FAIL midrst_rr got v%0h i%0h exp v1 i0", gv, gi); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            req  = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            ack  = $urandom_range(0, 1) == 1;
            tick();
            checks++;
            if (gv !== m_valid || pc !== (IW+1)'(model_count()) ||
                goh !== (m_valid ? N'(1) << m_idx : N'(0)) ||
                (m_valid && gi !== IW'(m_idx))) begin
                errors++;
                $display("FAIL random cyc %0d got v%0h i%0h oh%0h pc%0h exp v%0h i%0h pc%0h",
                         c, gv, gi, goh, pc, m_valid, m_idx, model_count());
            end
        end
        req = '0; ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_latch();
        test_round_robin();
        test_starvation();
        test_rearm();
        test_mode_switch();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
